// File: rtl/button_mode_sequencer_if.sv
// Button/mode bundle between the board push-buttons and the display mode logic.
interface button_mode_sequencer_if #(
    parameter int MODE_W = 2
);
    logic [1:0]        buttons;
    logic [1:0]        pressed;
    logic              up_pulse;
    logic              down_pulse;
    logic [MODE_W-1:0] mode;

    modport master (
        output buttons,
        input  pressed,
        input  up_pulse,
        input  down_pulse,
        input  mode
    );

    modport slave (
        input  buttons,
        output pressed,
        output up_pulse,
        output down_pulse,
        output mode
    );
endinterface

// File: rtl/button_mode_sequencer.sv
// Push-button front end: synchronise, debounce and auto-repeat two active-low buttons,
// and step the registered display mode up (button0) or down (button1).
module button_mode_sequencer #(
    parameter int DEBOUNCE_CYCLES = 100000,
    parameter int REPEAT_DELAY    = 5000000,
    parameter int REPEAT_PERIOD   = 2000000,
    parameter int MODE_COUNT      = 4,
    parameter int MODE_W          = 2
) (
    input  logic                   clock,
    input  logic                   resetn,
    button_mode_sequencer_if.slave bus
);
    localparam int CNT_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int HOLD_W = $clog2(REPEAT_DELAY + REPEAT_PERIOD + 1);

    localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_ONE   = HOLD_W'(1);
    localparam logic [HOLD_W-1:0] HOLD_FIRST = HOLD_W'(REPEAT_DELAY);
    localparam logic [HOLD_W-1:0] HOLD_NEXT  = HOLD_W'(REPEAT_DELAY + REPEAT_PERIOD);
    localparam logic [MODE_W-1:0] MODE_ONE   = MODE_W'(1);
    localparam logic [MODE_W-1:0] MODE_LAST  = MODE_W'(MODE_COUNT - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ARM  = 2'd1;
    localparam logic [1:0] ST_HELD = 2'd2;
    localparam logic [1:0] ST_REL  = 2'd3;

    // Synchronisers hold the raw (active-low) level, so reset value 1 means released.
    logic [1:0]        sync1_q, sync1_d;
    logic [1:0]        sync2_q, sync2_d;
    logic [1:0]        btn_s;
    logic [1:0]        btn_level;
    logic [1:0]        btn_ev;
    logic              up_q, up_d;
    logic              down_q, down_d;
    logic [MODE_W-1:0] mode_q, mode_d;

    always_comb begin
        sync1_d = bus.buttons;
        sync2_d = sync1_q;
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            sync1_q <= 2'b11;
            sync2_q <= 2'b11;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

    assign btn_s = ~sync2_q;

    for (genvar i = 0; i < 2; i++) begin : g_btn
        logic [1:0]        state_q, state_d;
        logic [CNT_W-1:0]  cnt_q, cnt_d;
        logic [HOLD_W-1:0] hold_q, hold_d;
        logic [HOLD_W-1:0] hold_inc;
        logic              lvl_q, lvl_d;
        logic              ev_q, ev_d;

        always_comb begin
            state_d  = state_q;
            cnt_d    = cnt_q;
            hold_d   = hold_q;
            lvl_d    = lvl_q;
            ev_d     = 1'b0;
            hold_inc = hold_q + HOLD_ONE;
            case (state_q)
                ST_IDLE: begin
                    if (btn_s[i]) begin
                        cnt_d   = CNT_ONE;
                        state_d = ST_ARM;
                    end
                end
                ST_ARM: begin
                    if (!btn_s[i]) begin
                        state_d = ST_IDLE;
                    end else if (cnt_q == CNT_LAST) begin
                        state_d = ST_HELD;
                        lvl_d   = 1'b1;
                        ev_d    = 1'b1;
                        hold_d  = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                ST_HELD: begin
                    if (!btn_s[i]) begin
                        cnt_d   = CNT_ONE;
                        state_d = ST_REL;
                    end else begin
                        hold_d = hold_inc;
                        // After the first repeat, hold cycles between REPEAT_DELAY and the next repeat point.
                        if (hold_inc == HOLD_FIRST) begin
                            ev_d = 1'b1;
                        end else if (hold_inc == HOLD_NEXT) begin
                            ev_d   = 1'b1;
                            hold_d = HOLD_FIRST;
                        end
                    end
                end
                default: begin
                    if (btn_s[i]) begin
                        state_d = ST_HELD;
                    end else if (cnt_q == CNT_LAST) begin
                        state_d = ST_IDLE;
                        lvl_d   = 1'b0;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
            endcase
        end

        always_ff @(posedge clock or negedge resetn) begin
            if (!resetn) begin
                state_q <= ST_IDLE;
                cnt_q   <= '0;
                hold_q  <= '0;
                lvl_q   <= 1'b0;
                ev_q    <= 1'b0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                hold_q  <= hold_d;
                lvl_q   <= lvl_d;
                ev_q    <= ev_d;
            end
        end

        assign btn_level[i] = lvl_q;
        assign btn_ev[i]    = ev_q;
    end

    // Pulses and mode share one register stage so the mux sees both change on the same edge.
    always_comb begin
        up_d   = btn_ev[0];
        down_d = btn_ev[1];
        mode_d = mode_q;
        if (btn_ev == 2'b01) begin
            mode_d = (mode_q == MODE_LAST) ? '0 : mode_q + MODE_ONE;
        end else if (btn_ev == 2'b10) begin
            mode_d = (mode_q == '0) ? MODE_LAST : mode_q - MODE_ONE;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            up_q   <= 1'b0;
            down_q <= 1'b0;
            mode_q <= '0;
        end else begin
            up_q   <= up_d;
            down_q <= down_d;
            mode_q <= mode_d;
        end
    end

    assign bus.pressed    = btn_level;
    assign bus.up_pulse   = up_q;
    assign bus.down_pulse = down_q;
    assign bus.mode       = mode_q;
endmodule

// File: tb/tb_button_mode_sequencer.sv
// Bench for button_mode_sequencer: directed scenarios plus random button activity
// compared cycle by cycle against a run-length reference model.
`timescale 1ns/1ps
module tb_button_mode_sequencer;
    localparam int DEB = 4;
    localparam int RD  = 20;
    localparam int RP  = 8;
    localparam int MC  = 4;
    localparam int MW  = 2;

    logic clock  = 1'b0;
    logic resetn = 1'b0;
    always #50 clock = ~clock;

    button_mode_sequencer_if #(.MODE_W(MW)) bus ();

    button_mode_sequencer #(
        .DEBOUNCE_CYCLES(DEB),
        .REPEAT_DELAY   (RD),
        .REPEAT_PERIOD  (RP),
        .MODE_COUNT     (MC),
        .MODE_W         (MW)
    ) dut (
        .clock (clock),
        .resetn(resetn),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: a level flips after DEB consecutive disagreeing samples;
    // repeats are counted in samples held continuously since the accepted press.
    logic [1:0] m_sy1, m_sy2;
    logic [1:0] m_lvl, m_sprev, m_ev;
    int         m_run[2];
    int         m_held[2];
    logic       e_up, e_dn;
    int         e_mode;

    logic [5:0] act_vec;
    assign act_vec = {bus.pressed, bus.up_pulse, bus.down_pulse, bus.mode};

    function automatic logic [5:0] exp_vec();
        return {m_lvl, e_up, e_dn, MW'(e_mode)};
    endfunction

    task automatic model_reset();
        m_sy1  = 2'b11;
        m_sy2  = 2'b11;
        m_lvl  = 2'b00;
        m_sprev = 2'b00;
        m_ev   = 2'b00;
        m_run  = '{0, 0};
        m_held = '{0, 0};
        e_up   = 1'b0;
        e_dn   = 1'b0;
        e_mode = 0;
    endtask

    task automatic model_edge();
        logic s;
        e_up   = m_ev[0];
        e_dn   = m_ev[1];
        e_mode = (e_mode + int'(e_up) - int'(e_dn) + MC) % MC;
        for (int i = 0; i < 2; i++) begin
            s = ~m_sy2[i];
            m_ev[i] = 1'b0;
            if (s != m_lvl[i]) m_run[i]++;
            else m_run[i] = 0;
            if (m_lvl[i] && s && m_sprev[i]) begin
                m_held[i]++;
                if (m_held[i] == RD || (m_held[i] > RD && (m_held[i] - RD) % RP == 0))
                    m_ev[i] = 1'b1;
            end
            if (m_run[i] == DEB) begin
                m_lvl[i] = ~m_lvl[i];
                m_run[i] = 0;
                if (m_lvl[i]) begin
                    m_ev[i]   = 1'b1;
                    m_held[i] = 0;
                end
            end
            m_sprev[i] = s;
        end
        m_sy2 = m_sy1;
        m_sy1 = bus.buttons;
    endtask

    task automatic tick();
        @(posedge clock);
        if (!resetn) model_reset();
        else model_edge();
        #1;
    endtask

    task automatic apply_reset();
        @(negedge clock);
        resetn      = 1'b0;
        bus.buttons = 2'b11;
        model_reset();
        repeat (2) tick();
        @(negedge clock);
        resetn = 1'b1;
    endtask

    task automatic test_reset();
        int pulses;
        pulses = 0;
        @(negedge clock);
        resetn      = 1'b0;
        bus.buttons = 2'b11;
        model_reset();
        #1;
        n_checks++;
        if (act_vec !== 6'd0) begin
            n_fail++;
            $display("FAIL reset_state: got %b, want %b", act_vec, 6'd0);
        end
        repeat (2) tick();
        @(negedge clock);
        resetn = 1'b1;
        for (int k = 0; k < 50; k++) begin
            tick();
            n_checks++;
            if (act_vec !== exp_vec()) begin
                n_fail++;
                $display("FAIL idle_cycle%0d: got %b, want %b", k, act_vec, exp_vec());
            end
            pulses += int'(bus.up_pulse) + int'(bus.down_pulse);
        end
        n_checks++;
        if (pulses != 0 || bus.mode !== 2'd0 || bus.pressed !== 2'b00) begin
            n_fail++;
            $display("FAIL idle_summary: pulses=%0d mode=%0d pressed=%b, want 0/0/00",
                     pulses, bus.mode, bus.pressed);
        end
    endtask

    task automatic test_single_press();
        int pulses, first;
        pulses = 0;
        first  = -1;
        bus.buttons[0] = 1'b0;
        for (int k = 0; k < 30; k++) begin
            if (k == 10) bus.buttons[0] = 1'b1;
            tick();
            n_checks++;
            if (act_vec !== exp_vec()) begin
                n_fail++;
                $display("FAIL press_cycle%0d: got %b, want %b", k, act_vec, exp_vec());
            end
            if (bus.up_pulse) begin
                pulses++;
                if (first < 0) first = k;
            end
        end
        n_checks++;
        if (pulses != 1 || first != DEB + 2) begin
            n_fail++;
            $display("FAIL press_pulse: count=%0d at edge %0d, want 1 at edge %0d", pulses, first, DEB + 2);
        end
        n_checks++;
        if (bus.mode !== 2'd1 || bus.pressed !== 2'b00) begin
            n_fail++;
            $display("FAIL press_final: mode=%0d pressed=%b, want 1/00", bus.mode, bus.pressed);
        end
    endtask

    task automatic test_bounce();
        int pulses;
        pulses = 0;
        for (int k = 0; k < 35; k++) begin
            bus.buttons[0] = (k < 20) ? (((k / 2) % 2) == 1) : 1'b1;
            tick();
            n_checks++;
            if (act_vec !== exp_vec()) begin
                n_fail++;
                $display("FAIL bounce_cycle%0d: got %b, want %b", k, act_vec, exp_vec());
            end
            pulses += int'(bus.up_pulse);
        end
        n_checks++;
        if (pulses != 0 || bus.mode !== 2'd1) begin
            n_fail++;
            $display("FAIL bounce_reject: pulses=%0d mode=%0d, want 0/1", pulses, bus.mode);
        end
    endtask

    task automatic test_repeat();
        int offs[$];
        int modes[$];
        int exp_offs[5];
        int exp_modes[5];
        exp_offs  = '{0, RD, RD + RP, RD + 2 * RP, RD + 3 * RP};
        exp_modes = '{3, 2, 1, 0, 3};
        apply_reset();
        bus.buttons[1] = 1'b0;
        for (int k = 0; k < 70; k++) begin
            if (k == 50) bus.buttons[1] = 1'b1;
            tick();
            n_checks++;
            if (act_vec !== exp_vec()) begin
                n_fail++;
                $display("FAIL repeat_cycle%0d: got %b, want %b", k, act_vec, exp_vec());
            end
            if (bus.down_pulse) begin
                offs.push_back(k);
                modes.push_back(int'(bus.mode));
            end
        end
        n_checks++;
        if (offs.size() != 5) begin
            n_fail++;
            $display("FAIL repeat_count: got %0d down pulses, want 5", offs.size());
        end
        for (int i = 0; i < 5 && i < offs.size(); i++) begin
            n_checks++;
            if (offs[i] - offs[0] != exp_offs[i] || modes[i] != exp_modes[i]) begin
                n_fail++;
                $display("FAIL repeat_event%0d: offset %0d mode %0d, want offset %0d mode %0d",
                         i, offs[i] - offs[0], modes[i], exp_offs[i], exp_modes[i]);
            end
        end
    endtask

    task automatic test_both();
        int both, lone;
        both = 0;
        lone = 0;
        apply_reset();
        bus.buttons = 2'b00;
        for (int k = 0; k < 22; k++) begin
            if (k == 12) bus.buttons = 2'b11;
            tick();
            n_checks++;
            if (act_vec !== exp_vec()) begin
                n_fail++;
                $display("FAIL both_cycle%0d: got %b, want %b", k, act_vec, exp_vec());
            end
            if (bus.up_pulse && bus.down_pulse) both++;
            else if (bus.up_pulse || bus.down_pulse) lone++;
        end
        n_checks++;
        if (both != 1 || lone != 0 || bus.mode !== 2'd0) begin
            n_fail++;
            $display("FAIL both_same_cycle: both=%0d lone=%0d mode=%0d, want 1/0/0", both, lone, bus.mode);
        end
    endtask

    task automatic test_reset_held();
        int first, waited;
        first  = -1;
        waited = 0;
        apply_reset();
        for (int p = 0; p < 2; p++) begin
            for (int k = 0; k < 20; k++) begin
                bus.buttons[0] = (k >= 10);
                tick();
                n_checks++;
                if (act_vec !== exp_vec()) begin
                    n_fail++;
                    $display("FAIL rh_setup%0d_%0d: got %b, want %b", p, k, act_vec, exp_vec());
                end
            end
        end
        n_checks++;
        if (bus.mode !== 2'd2) begin
            n_fail++;
            $display("FAIL rh_mode_before: got %0d, want 2", bus.mode);
        end
        bus.buttons[0] = 1'b0;
        while (bus.pressed[0] !== 1'b1 && waited < 20) begin
            tick();
            waited++;
        end
        n_checks++;
        if (bus.pressed[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL rh_held_timeout: pressed=%b after %0d cycles, want pressed[0]=1", bus.pressed, waited);
        end
        @(negedge clock);
        resetn = 1'b0;
        model_reset();
        #1;
        n_checks++;
        if (bus.mode !== 2'd0 || bus.pressed !== 2'b00 || bus.up_pulse !== 1'b0) begin
            n_fail++;
            $display("FAIL rh_async_clear: mode=%0d pressed=%b up=%b, want 0/00/0",
                     bus.mode, bus.pressed, bus.up_pulse);
        end
        tick();
        @(negedge clock);
        resetn = 1'b1;
        for (int k = 0; k < 12; k++) begin
            tick();
            n_checks++;
            if (act_vec !== exp_vec()) begin
                n_fail++;
                $display("FAIL rh_after%0d: got %b, want %b", k, act_vec, exp_vec());
            end
            if (bus.up_pulse && first < 0) first = k;
        end
        n_checks++;
        if (first != DEB + 2 || bus.mode !== 2'd1) begin
            n_fail++;
            $display("FAIL rh_fresh_debounce: pulse at edge %0d mode=%0d, want edge %0d mode 1",
                     first, bus.mode, DEB + 2);
        end
        bus.buttons = 2'b11;
        repeat (10) tick();
    endtask

    task automatic test_random();
        int rl[2];
        rl = '{0, 0};
        apply_reset();
        for (int k = 0; k < 1500; k++) begin
            for (int i = 0; i < 2; i++) begin
                if (rl[i] == 0) begin
                    bus.buttons[i] = ~bus.buttons[i];
                    rl[i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(20, 60))
                                                        : int'($urandom_range(1, 6));
                end
                rl[i]--;
            end
            tick();
            n_checks++;
            if (act_vec !== exp_vec()) begin
                n_fail++;
                $display("FAIL random_cycle%0d: got %b, want %b", k, act_vec, exp_vec());
            end
        end
    endtask

    initial begin
        bus.buttons = 2'b11;
        model_reset();
        test_reset();
        test_single_press();
        test_bounce();
        test_repeat();
        test_both();
        test_reset_held();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
